// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-information and pipeline-control bundle between the datapath and pipe_hazard_ctrl.
// master: the hazard controller; slave: the datapath that consumes the controls.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             id_halt;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_redirect;
    logic             wb_halt;
    logic             mem_busy;

    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             pc_redirect;
    logic             halted;
    logic             drain_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
        input  ex_rd, ex_mem_read, ex_redirect, wb_halt, mem_busy,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush, pc_redirect, halted, drain_err,
        output stall_cnt, flush_cnt
    );

    modport slave (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
        output ex_rd, ex_mem_read, ex_redirect, wb_halt, mem_busy,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_flush, pc_redirect, halted, drain_err,
        input  stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: buffer enables, bubbles, PC redirect and halt-drain FSM.
// Optional macro PIPE_PERF_CNT_EN adds saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int DRAIN_MAX = 8,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.master bus
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    localparam int DW = $clog2(DRAIN_MAX + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);

    state_t        state;
    logic [DW-1:0] drain_cnt;
    logic          drain_err_q;
    logic          load_use;

    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, pc_redirect, halted;

    assign load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                      ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                       (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

    // Priority: mem_busy > ex_redirect > load-use > id_halt; everything quiet while in reset.
    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_mem_en   = 1'b0;
        mem_wb_en   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pc_redirect = 1'b0;
        halted      = 1'b0;
        if (rst_n) begin
            case (state)
                RUN: begin
                    if (!bus.mem_busy) begin
                        pc_en     = 1'b1;
                        if_id_en  = 1'b1;
                        id_ex_en  = 1'b1;
                        ex_mem_en = 1'b1;
                        mem_wb_en = 1'b1;
                        if (bus.ex_redirect) begin
                            pc_redirect = 1'b1;
                            if_id_flush = 1'b1;
                            id_ex_flush = 1'b1;
                        end else if (load_use) begin
                            pc_en       = 1'b0;
                            if_id_en    = 1'b0;
                            id_ex_flush = 1'b1;
                        end else if (bus.id_halt) begin
                            pc_en       = 1'b0;
                            if_id_flush = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Redirects are ignored here: only older instructions remain in flight.
                    if (!bus.mem_busy) begin
                        if_id_en    = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_en    = 1'b1;
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                    end
                end
                HALTED: halted = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            drain_cnt   <= '0;
            drain_err_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!bus.mem_busy && !bus.ex_redirect && !load_use && bus.id_halt) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    // Watchdog only counts cycles in which the pipeline actually advanced.
                    if (!bus.mem_busy) begin
                        if (bus.wb_halt) begin
                            state <= HALTED;
                        end else if (drain_cnt == DRAIN_LAST) begin
                            drain_err_q <= 1'b1;
                            state       <= HALTED;
                        end else begin
                            drain_cnt <= drain_cnt + DW'(1);
                        end
                    end
                end
                HALTED: ;
                default: state <= RUN;
            endcase
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.if_id_en    = if_id_en;
    assign bus.id_ex_en    = id_ex_en;
    assign bus.ex_mem_en   = ex_mem_en;
    assign bus.mem_wb_en   = mem_wb_en;
    assign bus.if_id_flush = if_id_flush;
    assign bus.id_ex_flush = id_ex_flush;
    assign bus.pc_redirect = pc_redirect;
    assign bus.halted      = halted;
    assign bus.drain_err   = drain_err_q;

`ifdef PIPE_PERF_CNT_EN
    logic             stall_evt;
    logic             flush_evt;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    assign stall_evt = (state != HALTED) &&
                       (bus.mem_busy || ((state == RUN) && !bus.ex_redirect && load_use));
    assign flush_evt = (state == RUN) && !bus.mem_busy && bus.ex_redirect;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_evt && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
            if (flush_evt && (flush_q != '1))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
`else
    assign bus.stall_cnt = '0;
    assign bus.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; counter expectations follow PIPE_PERF_CNT_EN.
module tb_pipe_hazard_ctrl;
    localparam int CNT_W     = 16;
    localparam int DRAIN_MAX = 8;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Control vector order: pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    // if_id_flush, id_ex_flush, pc_redirect, halted
    localparam logic [8:0] C_NORMAL   = 9'b111110000;
    localparam logic [8:0] C_LOADUSE  = 9'b001110100;
    localparam logic [8:0] C_REDIRECT = 9'b111111110;
    localparam logic [8:0] C_HALT_IN  = 9'b011111000;
    localparam logic [8:0] C_FROZEN   = 9'b000000000;
    localparam logic [8:0] C_HALTED   = 9'b000000001;
    localparam logic [8:0] M_DRAIN    = 9'b101111111;
    localparam logic [8:0] C_DRAIN    = 9'b001111000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();
    pipe_hazard_ctrl #(.DRAIN_MAX(DRAIN_MAX), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int tests = 0;
    int failed = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    logic [8:0] ctl;
    assign ctl = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                  bus.if_id_flush, bus.id_ex_flush, bus.pc_redirect, bus.halted};

    function automatic logic [CNT_W-1:0] cnt_exp(input int n);
        return PERF ? CNT_W'(n) : '0;
    endfunction

    task automatic idle();
        bus.id_rs1      = 5'd0;
        bus.id_rs2      = 5'd0;
        bus.id_use_rs1  = 1'b0;
        bus.id_use_rs2  = 1'b0;
        bus.id_halt     = 1'b0;
        bus.ex_rd       = 5'd0;
        bus.ex_mem_read = 1'b0;
        bus.ex_redirect = 1'b0;
        bus.wb_halt     = 1'b0;
        bus.mem_busy    = 1'b0;
    endtask

    task automatic set_load_use_rs1();
        bus.ex_mem_read = 1'b1;
        bus.ex_rd       = 5'd5;
        bus.id_rs1      = 5'd5;
        bus.id_use_rs1  = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        bus.ex_redirect = 1'b1;
        bus.id_halt = 1'b1;
        #1;
        tests++;
        if (ctl !== C_FROZEN) begin
            failed++;
            $display("[TB] FAIL reset_ctl: got %b expected %b", ctl, C_FROZEN);
        end
        tests++;
        if (bus.drain_err !== 1'b0 || bus.stall_cnt !== '0 || bus.flush_cnt !== '0) begin
            failed++;
            $display("[TB] FAIL reset_state: got err=%b stall=%0d flush=%0d expected 0/0/0",
                     bus.drain_err, bus.stall_cnt, bus.flush_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        #1;
        tests++;
        if (ctl !== C_NORMAL) begin
            failed++;
            $display("[TB] FAIL post_reset_normal: got %b expected %b", ctl, C_NORMAL);
        end
        @(negedge clk);
    endtask

    task automatic test_load_use();
        set_load_use_rs1();
        #1;
        tests++;
        if (ctl !== C_LOADUSE) begin
            failed++;
            $display("[TB] FAIL load_use_rs1: got %b expected %b", ctl, C_LOADUSE);
        end
        @(negedge clk);
        exp_stall++;
        idle();
        #1;
        tests++;
        if (ctl !== C_NORMAL) begin
            failed++;
            $display("[TB] FAIL load_use_release: got %b expected %b", ctl, C_NORMAL);
        end
        tests++;
        if (bus.stall_cnt !== cnt_exp(exp_stall)) begin
            failed++;
            $display("[TB] FAIL load_use_stall_cnt: got %0d expected %0d", bus.stall_cnt, cnt_exp(exp_stall));
        end
        bus.ex_mem_read = 1'b1;
        bus.ex_rd = 5'd0;
        bus.id_use_rs1 = 1'b1;
        #1;
        tests++;
        if (ctl !== C_NORMAL) begin
            failed++;
            $display("[TB] FAIL load_use_x0: got %b expected %b", ctl, C_NORMAL);
        end
        @(negedge clk);
        idle();
        bus.ex_mem_read = 1'b1;
        bus.ex_rd = 5'd7;
        bus.id_rs1 = 5'd3;
        bus.id_use_rs1 = 1'b1;
        bus.id_rs2 = 5'd7;
        bus.id_use_rs2 = 1'b1;
        #1;
        tests++;
        if (ctl !== C_LOADUSE) begin
            failed++;
            $display("[TB] FAIL load_use_rs2: got %b expected %b", ctl, C_LOADUSE);
        end
        @(negedge clk);
        exp_stall++;
        bus.id_rs1 = 5'd7;
        bus.id_use_rs1 = 1'b0;
        bus.id_use_rs2 = 1'b0;
        #1;
        tests++;
        if (ctl !== C_NORMAL) begin
            failed++;
            $display("[TB] FAIL load_use_unread: got %b expected %b", ctl, C_NORMAL);
        end
        @(negedge clk);
        idle();
        set_load_use_rs1();
        bus.ex_mem_read = 1'b0;
        #1;
        tests++;
        if (ctl !== C_NORMAL) begin
            failed++;
            $display("[TB] FAIL no_load_match: got %b expected %b", ctl, C_NORMAL);
        end
        @(negedge clk);
        idle();
        tests++;
        if (bus.stall_cnt !== cnt_exp(exp_stall)) begin
            failed++;
            $display("[TB] FAIL load_use_stall_total: got %0d expected %0d", bus.stall_cnt, cnt_exp(exp_stall));
        end
    endtask

    task automatic test_redirect_priority();
        set_load_use_rs1();
        bus.ex_redirect = 1'b1;
        bus.id_halt = 1'b1;
        #1;
        tests++;
        if (ctl !== C_REDIRECT) begin
            failed++;
            $display("[TB] FAIL redirect_over_load_use: got %b expected %b", ctl, C_REDIRECT);
        end
        @(negedge clk);
        exp_flush++;
        idle();
        #1;
        tests++;
        if (ctl !== C_NORMAL) begin
            failed++;
            $display("[TB] FAIL redirect_halt_squashed: got %b expected %b", ctl, C_NORMAL);
        end
        tests++;
        if (bus.stall_cnt !== cnt_exp(exp_stall) || bus.flush_cnt !== cnt_exp(exp_flush)) begin
            failed++;
            $display("[TB] FAIL redirect_counters: got stall=%0d flush=%0d expected %0d/%0d",
                     bus.stall_cnt, bus.flush_cnt, cnt_exp(exp_stall), cnt_exp(exp_flush));
        end
        @(negedge clk);
    endtask

    task automatic test_busy_load_use();
        set_load_use_rs1();
        bus.mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (ctl !== C_FROZEN) begin
                failed++;
                $display("[TB] FAIL busy_freeze[%0d]: got %b expected %b", i, ctl, C_FROZEN);
            end
            @(negedge clk);
            exp_stall++;
        end
        bus.mem_busy = 1'b0;
        #1;
        tests++;
        if (ctl !== C_LOADUSE) begin
            failed++;
            $display("[TB] FAIL busy_then_bubble: got %b expected %b", ctl, C_LOADUSE);
        end
        @(negedge clk);
        exp_stall++;
        idle();
        #1;
        tests++;
        if (ctl !== C_NORMAL) begin
            failed++;
            $display("[TB] FAIL busy_release: got %b expected %b", ctl, C_NORMAL);
        end
        tests++;
        if (bus.stall_cnt !== cnt_exp(exp_stall) || bus.flush_cnt !== cnt_exp(exp_flush)) begin
            failed++;
            $display("[TB] FAIL busy_counters: got stall=%0d flush=%0d expected %0d/%0d",
                     bus.stall_cnt, bus.flush_cnt, cnt_exp(exp_stall), cnt_exp(exp_flush));
        end
        @(negedge clk);
    endtask

    task automatic test_halt_drain();
        idle();
        bus.id_halt = 1'b1;
        #1;
        tests++;
        if (ctl !== C_HALT_IN) begin
            failed++;
            $display("[TB] FAIL halt_entry: got %b expected %b", ctl, C_HALT_IN);
        end
        @(negedge clk);
        idle();
        for (int c = 1; c <= 3; c++) begin
            bus.ex_redirect = (c == 1);
            bus.wb_halt = (c == 3);
            #1;
            tests++;
            if ((ctl & M_DRAIN) !== C_DRAIN) begin
                failed++;
                $display("[TB] FAIL drain_cycle[%0d]: got %b expected %b (mask %b)", c, ctl, C_DRAIN, M_DRAIN);
            end
            @(negedge clk);
        end
        idle();
        bus.mem_busy = 1'b1;
        bus.ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (ctl !== C_HALTED) begin
                failed++;
                $display("[TB] FAIL halted_hold[%0d]: got %b expected %b", i, ctl, C_HALTED);
            end
            @(negedge clk);
        end
        idle();
        tests++;
        if (bus.stall_cnt !== cnt_exp(exp_stall) || bus.flush_cnt !== cnt_exp(exp_flush) || bus.drain_err !== 1'b0) begin
            failed++;
            $display("[TB] FAIL halted_counters: got stall=%0d flush=%0d err=%b expected %0d/%0d/0",
                     bus.stall_cnt, bus.flush_cnt, bus.drain_err, cnt_exp(exp_stall), cnt_exp(exp_flush));
        end
    endtask

    task automatic test_watchdog();
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        exp_stall = 0;
        exp_flush = 0;
        bus.id_halt = 1'b1;
        @(negedge clk);
        idle();
        bus.mem_busy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++;
            if (ctl !== C_FROZEN) begin
                failed++;
                $display("[TB] FAIL drain_busy[%0d]: got %b expected %b", i, ctl, C_FROZEN);
            end
            @(negedge clk);
            exp_stall++;
        end
        bus.mem_busy = 1'b0;
        for (int k = 1; k <= DRAIN_MAX; k++) begin
            #1;
            tests++;
            if ((ctl & M_DRAIN) !== C_DRAIN || bus.drain_err !== 1'b0) begin
                failed++;
                $display("[TB] FAIL watchdog_drain[%0d]: got %b err=%b expected %b err=0", k, ctl, bus.drain_err, C_DRAIN);
            end
            @(negedge clk);
        end
        #1;
        tests++;
        if (ctl !== C_HALTED || bus.drain_err !== 1'b1) begin
            failed++;
            $display("[TB] FAIL watchdog_trip: got %b err=%b expected %b err=1", ctl, bus.drain_err, C_HALTED);
        end
        tests++;
        if (bus.stall_cnt !== cnt_exp(exp_stall)) begin
            failed++;
            $display("[TB] FAIL watchdog_stall_cnt: got %0d expected %0d", bus.stall_cnt, cnt_exp(exp_stall));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_drain();
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        exp_stall = 0;
        exp_flush = 0;
        set_load_use_rs1();
        @(negedge clk);
        idle();
        bus.ex_redirect = 1'b1;
        @(negedge clk);
        idle();
        bus.id_halt = 1'b1;
        @(negedge clk);
        idle();
        #1;
        tests++;
        if ((ctl & M_DRAIN) !== C_DRAIN) begin
            failed++;
            $display("[TB] FAIL pre_reset_drain: got %b expected %b", ctl, C_DRAIN);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (ctl !== C_FROZEN || bus.stall_cnt !== '0 || bus.flush_cnt !== '0) begin
            failed++;
            $display("[TB] FAIL mid_drain_reset: got %b stall=%0d flush=%0d expected %b/0/0",
                     ctl, bus.stall_cnt, bus.flush_cnt, C_FROZEN);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (ctl !== C_NORMAL || bus.drain_err !== 1'b0) begin
            failed++;
            $display("[TB] FAIL mid_drain_release: got %b err=%b expected %b err=0", ctl, bus.drain_err, C_NORMAL);
        end
        @(negedge clk);
        #1;
        tests++;
        if (ctl !== C_NORMAL) begin
            failed++;
            $display("[TB] FAIL mid_drain_stays_run: got %b expected %b", ctl, C_NORMAL);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_redirect_priority();
        test_busy_load_use();
        test_halt_drain();
        test_watchdog();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline buffers IF/ID, ID/EX, EX/MEM and MEM/WB.
- Generates per-buffer load enables, bubble/flush controls and the PC redirect strobe.
- Resolves data-memory wait, EX-stage branch/jump redirect and load-use hazards.
- Runs the halt-drain FSM that retires in-flight instructions and then freezes the core.

Parameters:
DRAIN_MAX, 8, max cycles in DRAIN before watchdog error
CNT_W, 16, width of performance counters

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs1  in  5  rs1 index of instruction in ID
id_rs2  in  5  rs2 index of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
id_halt  in  1  halt decoded in ID
ex_rd  in  5  destination of instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_redirect  in  1  taken branch or jump resolved in EX
wb_halt  in  1  halt instruction in WB (Halt bit of MEM/WB)
mem_busy  in  1  data memory not ready; freeze request
pc_en  out  1  PC register load enable
if_id_en  out  1  IF/ID load enable
id_ex_en  out  1  ID/EX load enable
ex_mem_en  out  1  EX/MEM load enable
mem_wb_en  out  1  MEM/WB load enable
if_id_flush  out  1  load bubble into IF/ID
id_ex_flush  out  1  load bubble into ID/EX (all control bits 0)
pc_redirect  out  1  select redirect target for PC
halted  out  1  core halted
drain_err  out  1  sticky watchdog error
stall_cnt  out  CNT_W  load-use + mem stall cycles
flush_cnt  out  CNT_W  redirect events

Behaviour:
- States: RUN, DRAIN, HALTED. Reset (async, rst_n=0) -> RUN, drain counter 0, drain_err=0, counters 0. While rst_n=0 all *_en=0, flushes=0, pc_redirect=0, halted=0.
- Outputs combinational from state and inputs; state, watchdog and counters update on rising clk.
- Priority per cycle: mem_busy > ex_redirect > load-use > id_halt.
- mem_busy=1 (any state except HALTED):
  - All *_en=0, flushes=0, pc_redirect=0.
  - No state change; watchdog does not advance.
  - stall_cnt +1.
- Redirect (RUN, !mem_busy, ex_redirect=1):
  - pc_redirect=1, if_id_flush=1, id_ex_flush=1, all *_en=1.
  - flush_cnt +1.
  - Any simultaneous load-use or id_halt is squashed; state stays RUN.
- Load-use (RUN, no higher event): ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
  - pc_en=0, if_id_en=0, id_ex_flush=1; other enables 1.
  - Exactly one bubble per hazard; stall_cnt +1.
- Halt entry (RUN, id_halt, no higher event):
  - This cycle: normal advance (halt moves to ID/EX), pc_en=0, if_id_flush=1.
  - Next state DRAIN.
- DRAIN:
  - pc_en=0, if_id_flush=1, id_ex_en/ex_mem_en/mem_wb_en=1.
  - ex_redirect is ignored (older instructions already passed).
  - wb_halt=1 -> HALTED.
  - Watchdog increments each non-busy cycle; reaching DRAIN_MAX -> drain_err=1, HALTED.
- HALTED: all *_en=0, flushes=0, halted=1; only reset exits. mem_busy is ignored.
- Counters saturate at all-ones; they do not wrap.

Optional Feature:
- PIPE_PERF_CNT_EN defined: stall_cnt and flush_cnt are implemented as described above.
- PIPE_PERF_CNT_EN undefined: no counter flops; both outputs tied to 0.

Test Plan:
- Reset mid-DRAIN: id_halt, then rst_n=0 for 1 cycle -> state RUN, halted=0, drain_err=0, counters 0; with inputs idle after release, all *_en=1.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1, then normal flow; stall_cnt=1. Same with ex_rd=0 -> no stall.
- Redirect + load-use same cycle: ex_redirect=1 with a load-use match -> pc_redirect=1, both flushes=1, pc_en=1; stall_cnt unchanged, flush_cnt=1.
- Halt drain: id_halt at cycle N, wb_halt at N+3 -> DRAIN for cycles N+1..N+3, halted=1 from N+4, all enables 0 thereafter, mem_busy ignored.
- mem_busy for 3 cycles during a load-use hazard -> 3 frozen cycles with no flush, then the 1-cycle bubble; stall_cnt=4.
- Watchdog: DRAIN_MAX=8, wb_halt never asserted -> drain_err=1 and HALTED after 8 non-busy DRAIN cycles; busy cycles extend that window.
